// File: rtl/reg_dump_streamer_if.sv
// rtl/reg_dump_streamer_if.sv - debug-port and byte-stream bundle for reg_dump_streamer
//
// Purpose: groups the signals between the dump streamer, the computer's
// debug port and the byte-serial sink.
//
// Signals:
//   start            dump request from the debug host
//   busy             dump in progress
//   done             one-cycle pulse after the checksum byte is accepted
//   fetchPC          computer PC
//   debug_reg_select register index driven to the computer
//   debug_reg_out    register file read data for debug_reg_select
//   out_data         stream byte
//   out_valid        out_data valid
//   out_ready        sink ready
//
// Modports:
//   master - the streamer side
//   slave  - the computer / sink / host side
interface reg_dump_streamer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] fetchPC;
  logic [4:0]  debug_reg_select;
  logic [31:0] debug_reg_out;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  start, fetchPC, debug_reg_out, out_ready,
    output busy, done, debug_reg_select, out_data, out_valid
  );

  modport slave (
    output start, fetchPC, debug_reg_out, out_ready,
    input  busy, done, debug_reg_select, out_data, out_valid
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// rtl/reg_dump_streamer.sv - snapshot PC and register file into a framed byte stream
//
// Purpose: on a start request, latches the PC, walks the register file via
// debug_reg_select and emits HEADER, PC (LSB first), x0..x(NUM_REGS-1)
// (each LSB first) and an XOR checksum of all PC/register bytes over a
// valid/ready byte stream.
//
// Ports:
//   i_clk   system clock (same as the computer)
//   i_reset synchronous, active-high reset
//   bus     reg_dump_streamer_if.master (start/busy/done, debug port, stream)
//
// Parameters:
//   NUM_REGS registers dumped, 1..32
//   HEADER   frame start byte
module reg_dump_streamer #(
  parameter int          NUM_REGS = 32,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  reg_dump_streamer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PCB,
    S_SEL,
    S_REGB,
    S_CSUM
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_word;
  logic [7:0]  r_csum;
  logic [7:0]  r_data;
  logic [1:0]  r_k;
  logic [4:0]  r_sel;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic [1:0]  w_k_next;
  logic [7:0]  w_pc_byte_next;
  logic [7:0]  w_word_byte_next;

  assign w_accept         = r_valid && bus.out_ready;
  assign w_k_next         = r_k + 2'd1;
  // Next byte of the PC/word; only consumed while r_k < 3, so the 3->0 wrap is harmless.
  assign w_pc_byte_next   = 8'(r_pc   >> {w_k_next, 3'b000});
  assign w_word_byte_next = 8'(r_word >> {w_k_next, 3'b000});

  assign bus.out_data         = r_data;
  assign bus.out_valid        = r_valid;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.debug_reg_select = r_sel;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_word  <= '0;
      r_csum  <= '0;
      r_data  <= '0;
      r_k     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pc    <= bus.fetchPC;
            r_csum  <= '0;
            r_sel   <= '0;
            r_k     <= '0;
            r_data  <= HEADER;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_accept) begin
            r_k     <= '0;
            r_data  <= r_pc[7:0];
            r_state <= S_PCB;
          end
        end

        S_PCB: begin
          if (w_accept) begin
            r_csum <= r_csum ^ r_data;
            if (r_k == 2'd3) begin
              // Bubble cycle lets debug_reg_out settle for the selected register.
              r_valid <= 1'b0;
              r_state <= S_SEL;
            end else begin
              r_k    <= w_k_next;
              r_data <= w_pc_byte_next;
            end
          end
        end

        S_SEL: begin
          r_word  <= bus.debug_reg_out;
          r_data  <= bus.debug_reg_out[7:0];
          r_valid <= 1'b1;
          r_k     <= '0;
          r_state <= S_REGB;
        end

        S_REGB: begin
          if (w_accept) begin
            r_csum <= r_csum ^ r_data;
            if (r_k == 2'd3) begin
              if (r_sel == LAST_IDX) begin
                // Checksum must include the byte being accepted right now.
                r_data  <= r_csum ^ r_data;
                r_state <= S_CSUM;
              end else begin
                r_sel   <= r_sel + 5'd1;
                r_valid <= 1'b0;
                r_state <= S_SEL;
              end
            end else begin
              r_k    <= w_k_next;
              r_data <= w_word_byte_next;
            end
          end
        end

        S_CSUM: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_streamer.md
# reg_dump_streamer

Debug-side consumer of the computer's `fetchPC` and `debug_reg_out`/`debug_reg_select` debug port. On a start pulse it snapshots the PC, walks the register file through `debug_reg_select`, and emits a framed byte stream over a valid/ready handshake: header, PC, all registers, and a checksum. Sits between the computer top and a byte-serial transport (UART TX / host link). Dump is non-atomic: the CPU keeps running and each register is read when it is selected.

## Interface
- `NUM_REGS`, 32: registers dumped, x0..x(NUM_REGS-1); legal range 1..32.
- `HEADER`, 8'hA5: frame start byte.

- `clk`  in  1: system clock, same as computer.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: dump request; sampled only in IDLE.
- `fetchPC`  in  32: computer PC.
- `debug_reg_out`  in  32: register file read data for the current `debug_reg_select`; combinational in the same cycle.
- `debug_reg_select`  out  5: register index driven to the computer; registered.
- `out_data`  out  8: stream byte.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: sink accepts when `out_valid && out_ready`.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`.
- `done`  out  1: one-cycle pulse after the checksum byte is accepted.

## Operation
- Frame of 2+4+4·NUM_REGS bytes (134 at default):
  - `HEADER`
  - PC, LSB first
  - x0..x(NUM_REGS-1), each LSB first
  - checksum = XOR of every PC and register byte (the header is excluded)
- States:
  - IDLE: on `start`, latch `fetchPC` into `pc_q`, clear checksum, set reg index to 0 and `debug_reg_select`=0, go to HDR.
  - HDR: present `HEADER`; on accept go to PCB with byte count 0.
  - PCB: present `pc_q[8k+7:8k]` for k=0..3; on accepting k=3 go to SEL.
  - SEL: one cycle, `out_valid`=0; capture `debug_reg_out` into `word_q`; go to REGB with k=0.
  - REGB: present byte k of `word_q`. On accepting k=3:
    - if the index is NUM_REGS-1, go to CSUM;
    - otherwise increment the index and `debug_reg_select`, then go to SEL.
  - CSUM: present the checksum; on accept pulse `done` and go to IDLE.
- The checksum register XORs each PC/register byte as it is accepted.
- Outputs are registered. `out_data` is held stable while `out_valid && !out_ready`, and `out_valid` never drops before acceptance.
- `start` while busy is ignored; no queuing.
- `busy` is low in IDLE and high in every other state. In the cycle after the checksum is accepted: `done`=1, `busy`=0.
- Byte counter k wraps 3→0. The register index never exceeds NUM_REGS-1.

## Timing
- Reset values: state IDLE, `debug_reg_select`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, checksum 0.
- Reset asserted mid-dump aborts the frame the next edge: `out_valid` drops with no trailing bytes and no `done`.
- Start latency: `start` high at edge N (IDLE) → `out_valid`=1 with `HEADER` and `busy`=1 from edge N+1.
- With `out_ready` held high, one byte is accepted per cycle, plus one SEL bubble per register.
  - Total cycles from start to `done`: 1+1+4+NUM_REGS·5+1+1 = 168 at default.
- Register sampling: `debug_reg_select` changes on the edge entering SEL; `debug_reg_out` is captured at the end of that SEL cycle, i.e. one cycle of settling.
- PC value is the one present on the `start` edge; later PC changes do not affect the frame.

## Test plan
- **Reset idle:** hold `reset` 3 cycles → all outputs 0; `start` pulsed during reset produces no frame.
- **Full dump, ready=1:** stub regfile returns `{27'h0,sel}·0x01010101` (x5→0x05050505), PC=0x00000040.
  - Expected stream: A5, 40 00 00 00, then per-register bytes, then checksum = 0x40 XOR (XOR over registers).
  - Expected: 134 bytes and `done` at cycle 168.
- **Backpressure:** toggle `out_ready` pseudo-randomly → identical 134-byte stream; `out_data` stable whenever valid and not ready.
- **Start while busy:** second `start` at byte 10 → single frame only; a new frame starts only after `done` and a fresh `start`.
- **Mid-frame reset:** assert `reset` during register x7 → next cycle `out_valid`=0 and `busy`=0; a new `start` yields a complete fresh frame beginning with A5.
- **NUM_REGS=1:** 10-byte frame A5, PC(4), x0=00 00 00 00, checksum = XOR of PC bytes.
